// File: rtl/can_pkg.sv
// Shared CAN receive definitions: bit timing defaults, bus levels and frame state.
package can_pkg;

  localparam int unsigned CLKS_PER_BIT = 100;
  localparam int unsigned IDLE_BITS    = 11;

  localparam logic RECESSIVE = 1'b1;
  localparam logic DOMINANT  = 1'b0;

  typedef enum logic {
    IDLE,
    IN_FRAME
  } frame_state_e;

endpackage

// File: rtl/can_rx_sync.sv
// Two-flop synchronizer for the raw CAN RX pin plus a history flop
// that flags recessive-to-dominant transitions of the synchronized line.
module can_rx_sync
  import can_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic rx_in,
  output logic rx_sync,
  output logic rx_fall
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic rx_d_q,  rx_d_d;

  always_comb begin
    sync1_d = rx_in;
    sync2_d = sync1_q;
    rx_d_d  = sync2_q;
  end

  // Reset to recessive so a released reset on an idle bus never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= RECESSIVE;
      sync2_q <= RECESSIVE;
      rx_d_q  <= RECESSIVE;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      rx_d_q  <= rx_d_d;
    end
  end

  assign rx_sync = sync2_q;
  assign rx_fall = (rx_d_q == RECESSIVE) && (sync2_q == DOMINANT);

endmodule

// File: rtl/frame_detect.sv
// CAN start-of-frame detector: one-clock pulse on the dominant edge that opens
// a frame, then edges are ignored until the bus stays recessive for IDLE_BITS bits.
module frame_detect
  import can_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = can_pkg::CLKS_PER_BIT,
  parameter int unsigned IDLE_BITS    = can_pkg::IDLE_BITS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic can_rx,
  output logic sof_detect
);

  localparam int unsigned IDLE_CLKS = CLKS_PER_BIT * IDLE_BITS;
  localparam int unsigned CNT_W     = $clog2(IDLE_CLKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_CLKS - 1);

  logic rx_sync;
  logic rx_fall;

  frame_state_e     state_q, state_d;
  logic [CNT_W-1:0] rec_cnt_q, rec_cnt_d;
  logic             sof_q, sof_d;

  can_rx_sync u_rx_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx_in   (can_rx),
    .rx_sync (rx_sync),
    .rx_fall (rx_fall)
  );

  always_comb begin
    state_d   = state_q;
    rec_cnt_d = '0;
    sof_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_fall) begin
          state_d = IN_FRAME;
          sof_d   = 1'b1;
        end
      end
      IN_FRAME: begin
        // The IDLE_CLKS-th recessive sample ends the frame; edges resume next cycle.
        if (rx_sync == DOMINANT) begin
          rec_cnt_d = '0;
        end else if (rec_cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          rec_cnt_d = rec_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rec_cnt_q <= '0;
      sof_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rec_cnt_q <= rec_cnt_d;
      sof_q     <= sof_d;
    end
  end

  assign sof_detect = sof_q;

endmodule

// File: tb/tb_frame_detect.sv
// Bench for frame_detect: expected SOF pulse cycles are queued as stimulus is
// driven and matched against every pulse the DUT produces.
module tb_frame_detect;

  localparam int unsigned BIT_CLKS  = 100;
  localparam int unsigned IDLE_CLKS = 1100;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic can_rx = 1'b1;
  logic sof_detect;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_q[$];

  frame_detect #(
    .CLKS_PER_BIT (BIT_CLKS),
    .IDLE_BITS    (11)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .can_rx     (can_rx),
    .sof_detect (sof_detect)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t cyc=%0d)", tag, act, exp, $time, cyc);
    end
  endtask

  // Pulse scoreboard: a queued cycle must see sof_detect high, any other high is unexpected.
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() > 0 && exp_q[0] == cyc) begin
        void'(exp_q.pop_front());
        check("sof_pulse", int'(sof_detect), 1);
      end else if (sof_detect !== 1'b0) begin
        check("sof_unexpected", int'(sof_detect), 0);
      end
    end
  end

  // Holds can_rx at v for nclk clocks; a queued SOF lands 3 edges after the drive.
  task automatic drive(input logic v, input int unsigned nclk, input bit exp_sof);
    for (int unsigned i = 0; i < nclk; i++) begin
      @(negedge clk);
      can_rx = v;
      if (i == 0 && exp_sof) exp_q.push_back(cyc + 3);
    end
  endtask

  function automatic logic frame_bit(input int unsigned i, input int unsigned nbits);
    logic [15:0] pat;
    pat = 16'b0000110000010001;
    if (i >= nbits - 11) return 1'b1;
    if (i == nbits - 12) return 1'b0;
    return pat[15 - (i % 16)];
  endfunction

  task automatic send_frame(input int unsigned nbits);
    for (int unsigned i = 0; i < nbits; i++)
      drive(frame_bit(i, nbits), BIT_CLKS, (i == 0));
  endtask

  initial begin
    // Reset and first SOF 20 ns after release
    #1 rst_n = 1'b0;
    can_rx = 1'b1;
    #7 check("reset_sof", int'(sof_detect), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1, 1'b0);
    drive(1'b0, BIT_CLKS, 1'b1);
    drive(1'b1, IDLE_CLKS, 1'b0);

    // Full data frame: internal edges ignored
    send_frame(94);

    // Data frame, idle, error frame, idle, data frame
    drive(1'b1, 100, 1'b0);
    send_frame(94);
    drive(1'b1, 100, 1'b0);
    send_frame(84);
    drive(1'b1, 50, 1'b0);
    send_frame(94);

    // Recessive run one clock short of idle, then exactly idle
    drive(1'b0, BIT_CLKS, 1'b1);
    drive(1'b1, IDLE_CLKS - 1, 1'b0);
    drive(1'b0, BIT_CLKS, 1'b0);
    drive(1'b1, IDLE_CLKS, 1'b0);
    drive(1'b0, BIT_CLKS, 1'b1);
    drive(1'b1, IDLE_CLKS, 1'b0);

    // Reset mid-frame, then an immediate SOF without idle integration
    drive(1'b0, BIT_CLKS, 1'b1);
    drive(1'b1, 200, 1'b0);
    drive(1'b0, 50, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    can_rx = 1'b1;
    #1 check("midreset_sof", int'(sof_detect), 0);
    @(negedge clk);
    check("midreset_hold", int'(sof_detect), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 5, 1'b0);
    drive(1'b0, BIT_CLKS, 1'b1);
    drive(1'b1, IDLE_CLKS, 1'b0);

    // Single-clock dominant glitch in idle starts a frame
    drive(1'b0, 1, 1'b1);
    drive(1'b1, IDLE_CLKS - 1, 1'b0);
    drive(1'b0, 1, 1'b0);
    drive(1'b1, IDLE_CLKS, 1'b0);
    drive(1'b0, 1, 1'b1);
    drive(1'b1, IDLE_CLKS, 1'b0);

    drive(1'b1, 10, 1'b0);
    check("sb_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
